// File: rtl/output_port_unit.sv
// Per-output-port allocator and credit-driven link driver for one router output.
// Round-robin grant, wormhole hold until tail, small output FIFO with cut-through bypass.
module output_port_unit #(
  parameter int NUM_PORTS  = 5,
  parameter int FLIT_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_ack,
  output logic                 o_busy,
  output logic [2:0]           o_owner,
  input  logic                 i_flit_valid,
  input  logic [FLIT_W-1:0]    i_flit,
  output logic                 o_ready,
  output logic                 o_link_valid,
  output logic [FLIT_W-1:0]    o_link_flit,
  input  logic                 i_credit,
  output logic [1:0]           o_err
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [3:0]     CRED_MAX = CREDITS[3:0];
  localparam logic [3:0]     NP_C     = NUM_PORTS[3:0];
  localparam logic [2:0]     NP_LAST  = 3'(NUM_PORTS - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [2:0]             r_rr_ptr;
  logic [NUM_PORTS-1:0]   r_ack;
  logic [2:0]             r_owner;
  logic [FLIT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [3:0]             r_credits;
  logic                   r_link_valid;
  logic [FLIT_W-1:0]      r_link_flit;
  logic [1:0]             r_err;

  logic [2*NUM_PORTS-1:0] w_req_dbl;
  logic [NUM_PORTS-1:0]   w_req_rot;
  logic                   w_gnt_found;
  logic [2:0]             w_gnt_off;
  logic [3:0]             w_gnt_sum;
  logic [2:0]             w_gnt_idx;
  logic [2:0]             w_ptr_next;
  logic [NUM_PORTS-1:0]   w_ack_onehot;
  logic                   w_grant;

  logic w_empty, w_full, w_credit_ok, w_pop_fifo, w_ready;
  logic w_push, w_bypass, w_store, w_send, w_drop, w_is_tail;

  // Rotate requests so bit 0 is the port at the RR pointer; lowest set bit wins.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_rot = w_req_dbl[r_rr_ptr +: NUM_PORTS];

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_off   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_gnt_found = 1'b1;
        w_gnt_off   = 3'(k);
      end
    end
  end

  assign w_gnt_sum  = {1'b0, r_rr_ptr} + {1'b0, w_gnt_off};
  assign w_gnt_idx  = (w_gnt_sum >= NP_C) ? 3'(w_gnt_sum - NP_C) : w_gnt_sum[2:0];
  assign w_ptr_next = (w_gnt_idx == NP_LAST) ? 3'd0 : w_gnt_idx + 3'd1;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
      assign w_ack_onehot[gi] = (w_gnt_idx == 3'(gi));
    end
  endgenerate

  // Sends may use a credit arriving this cycle and may cut a flit straight through an empty FIFO.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_credit_ok = (r_credits != 4'd0) || i_credit;
  assign w_pop_fifo  = !w_empty && w_credit_ok;
  assign w_ready     = !w_full || w_pop_fifo;
  assign w_push      = i_flit_valid && w_ready && (r_state == S_ACTIVE);
  assign w_bypass    = w_empty && w_push && w_credit_ok;
  assign w_store     = w_push && !w_bypass;
  assign w_send      = w_pop_fifo || w_bypass;
  assign w_drop      = i_flit_valid && !w_push;
  assign w_is_tail   = i_flit[FLIT_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_grant      = 1'b1;
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_push && w_is_tail) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_ack <= w_grant ? w_ack_onehot : '0;
      if (w_grant) begin
        r_owner  <= w_gnt_idx;
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= i_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_store, w_pop_fifo})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_link_valid <= 1'b0;
      r_link_flit  <= '0;
    end else begin
      r_link_valid <= w_send;
      if (w_send) r_link_flit <= w_bypass ? i_flit : r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CRED_MAX;
      r_err     <= '0;
    end else begin
      if (w_send && !i_credit) begin
        r_credits <= r_credits - 4'd1;
      end else if (i_credit && !w_send) begin
        if (r_credits == CRED_MAX) r_err[1] <= 1'b1;
        else                       r_credits <= r_credits + 4'd1;
      end
      if (w_drop) r_err[0] <= 1'b1;
    end
  end

  assign o_ack        = r_ack;
  assign o_busy       = (r_state == S_ACTIVE);
  assign o_owner      = r_owner;
  assign o_ready      = w_ready;
  assign o_link_valid = r_link_valid;
  assign o_link_flit  = r_link_flit;
  assign o_err        = r_err;

endmodule

// File: tb/tb_output_port_unit.sv
// Directed self-checking bench for output_port_unit: allocation, wormhole hold, credits, errors, reset.
module tb_output_port_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  i_req = '0;
  logic [4:0]  o_ack;
  logic        o_busy;
  logic [2:0]  o_owner;
  logic        i_flit_valid = 1'b0;
  logic [31:0] i_flit = '0;
  logic        o_ready;
  logic        o_link_valid;
  logic [31:0] o_link_flit;
  logic        i_credit = 1'b0;
  logic [1:0]  o_err;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  output_port_unit #(.NUM_PORTS(5), .FLIT_W(32), .FIFO_DEPTH(4), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_ack(o_ack), .o_busy(o_busy), .o_owner(o_owner),
    .i_flit_valid(i_flit_valid), .i_flit(i_flit), .o_ready(o_ready),
    .o_link_valid(o_link_valid), .o_link_flit(o_link_flit), .i_credit(i_credit), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [1:0] t, input int p);
    return {t, 30'(p)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; i_req = '0; i_flit_valid = 1'b0; i_flit = '0; i_credit = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    checks++; if (o_ack !== 5'b0) begin errors++; $display("FAIL reset_ack got %b exp %b", o_ack, 5'b0); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_owner !== 3'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", o_owner); end
    checks++; if (o_link_valid !== 1'b0) begin errors++; $display("FAIL reset_link_valid got %b exp 0", o_link_valid); end
    checks++; if (o_link_flit !== 32'h0) begin errors++; $display("FAIL reset_link_flit got %h exp 0", o_link_flit); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", o_err); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    i_req = 5'b00100; cyc(); i_req = '0;
    checks++; if (o_ack !== 5'b00100) begin errors++; $display("FAIL single_ack got %b exp %b", o_ack, 5'b00100); end
    checks++; if (o_owner !== 3'd2) begin errors++; $display("FAIL single_owner got %0d exp 2", o_owner); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", o_busy); end
    cyc();
    checks++; if (o_ack !== 5'b0) begin errors++; $display("FAIL single_ack_pulse got %b exp 0", o_ack); end
    i_flit_valid = 1'b1; i_flit = mk(T_HT, 'h0A); cyc(); i_flit_valid = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear got %b exp 0", o_busy); end
    checks++; if (o_link_valid !== 1'b1 || o_link_flit !== mk(T_HT, 'h0A)) begin errors++;
      $display("FAIL single_link got v=%b %h exp v=1 %h", o_link_valid, o_link_flit, mk(T_HT, 'h0A)); end
    cyc();
    checks++; if (o_link_valid !== 1'b0) begin errors++; $display("FAIL single_link_idle got %b exp 0", o_link_valid); end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_owner [4];
    exp_owner = '{3'd0, 3'd2, 3'd4, 3'd0};
    apply_reset();
    i_req = 5'b10101;
    for (int p = 0; p < 4; p++) begin
      cyc();
      checks++; if (o_ack !== (5'b00001 << exp_owner[p]) || o_owner !== exp_owner[p]) begin errors++;
        $display("FAIL rr_grant%0d got ack=%b owner=%0d exp owner=%0d", p, o_ack, o_owner, exp_owner[p]); end
      for (int f = 0; f < 3; f++) begin
        i_flit_valid = 1'b1; i_credit = 1'b1;
        i_flit = mk((f == 0) ? T_HEAD : (f == 1) ? T_BODY : T_TAIL, p * 16 + f);
        cyc();
      end
      i_flit_valid = 1'b0; i_credit = 1'b0;
      checks++; if (o_busy !== 1'b0 || o_link_flit !== mk(T_TAIL, p * 16 + 2)) begin errors++;
        $display("FAIL rr_tail%0d got busy=%b flit=%h exp busy=0 flit=%h", p, o_busy, o_link_flit, mk(T_TAIL, p * 16 + 2)); end
    end
    i_req = '0;
    $display("test_round_robin done");
  endtask

  task automatic test_wormhole();
    apply_reset();
    i_req = 5'b00010; cyc();
    checks++; if (o_ack !== 5'b00010) begin errors++; $display("FAIL worm_grant got %b exp %b", o_ack, 5'b00010); end
    i_req = 5'b11111; i_flit_valid = 1'b1; i_flit = mk(T_HEAD, 1); cyc(); i_flit_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      checks++; if (o_ack !== 5'b0 || o_busy !== 1'b1) begin errors++;
        $display("FAIL worm_hold%0d got ack=%b busy=%b exp ack=0 busy=1", c, o_ack, o_busy); end
    end
    i_flit_valid = 1'b1; i_flit = mk(T_TAIL, 2); cyc(); i_flit_valid = 1'b0;
    checks++; if (o_ack !== 5'b0 || o_busy !== 1'b0) begin errors++;
      $display("FAIL worm_tail got ack=%b busy=%b exp ack=0 busy=0", o_ack, o_busy); end
    cyc();
    checks++; if (o_ack !== 5'b00100 || o_owner !== 3'd2) begin errors++;
      $display("FAIL worm_next got ack=%b owner=%0d exp ack=00100 owner=2", o_ack, o_owner); end
    i_req = '0;
    $display("test_wormhole done");
  endtask

  task automatic test_credit_stall();
    apply_reset();
    i_req = 5'b00001; cyc(); i_req = '0;
    for (int k = 1; k <= 6; k++) begin
      i_flit_valid = 1'b1;
      i_flit = mk((k == 1) ? T_HEAD : (k == 6) ? T_TAIL : T_BODY, 'h100 + k);
      cyc();
      if (k <= 4) begin
        checks++; if (o_link_valid !== 1'b1 || o_link_flit !== mk((k == 1) ? T_HEAD : T_BODY, 'h100 + k)) begin errors++;
          $display("FAIL stall_send%0d got v=%b %h exp v=1", k, o_link_valid, o_link_flit); end
      end else begin
        checks++; if (o_link_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got v=%b exp 0", k, o_link_valid); end
      end
    end
    i_flit_valid = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b exp 0", o_busy); end
    cyc();
    checks++; if (o_link_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", o_link_valid); end
    for (int k = 5; k <= 6; k++) begin
      i_credit = 1'b1; cyc(); i_credit = 1'b0;
      checks++; if (o_link_valid !== 1'b1 || o_link_flit !== mk((k == 6) ? T_TAIL : T_BODY, 'h100 + k)) begin errors++;
        $display("FAIL stall_release%0d got v=%b %h exp v=1 %h", k, o_link_valid, o_link_flit, mk((k == 6) ? T_TAIL : T_BODY, 'h100 + k)); end
      cyc();
      checks++; if (o_link_valid !== 1'b0) begin errors++; $display("FAIL stall_gap%0d got %b exp 0", k, o_link_valid); end
    end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL stall_err got %b exp 00", o_err); end
    $display("test_credit_stall done");
  endtask

  task automatic test_errors();
    apply_reset();
    i_req = 5'b00001; cyc(); i_req = '0;
    for (int k = 0; k < 4; k++) begin
      i_flit_valid = 1'b1; i_flit = mk((k == 0) ? T_HEAD : T_BODY, k); cyc();
    end
    for (int k = 0; k < 4; k++) begin
      i_flit = mk(T_BODY, 'h10 + k); cyc();
    end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL err_full_ready got %b exp 0", o_ready); end
    i_flit = mk(T_BODY, 'h20); cyc(); i_flit_valid = 1'b0;
    checks++; if (o_err !== 2'b01 || o_link_valid !== 1'b0) begin errors++;
      $display("FAIL err_drop got err=%b v=%b exp err=01 v=0", o_err, o_link_valid); end
    i_credit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++; if (o_link_valid !== 1'b1 || o_link_flit !== mk(T_BODY, 'h10 + k)) begin errors++;
        $display("FAIL err_drain%0d got v=%b %h exp v=1 %h", k, o_link_valid, o_link_flit, mk(T_BODY, 'h10 + k)); end
    end
    for (int k = 0; k < 4; k++) cyc();
    checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL err_refill got %b exp 01", o_err); end
    cyc(); i_credit = 1'b0;
    checks++; if (o_err !== 2'b11) begin errors++; $display("FAIL err_credit_ovf got %b exp 11", o_err); end
    for (int k = 0; k < 5; k++) begin
      i_flit_valid = 1'b1; i_flit = mk((k == 4) ? T_TAIL : T_BODY, 'h30 + k); cyc();
      checks++; if (o_link_valid !== (k < 4)) begin errors++;
        $display("FAIL err_credit_cap%0d got v=%b exp %b", k, o_link_valid, (k < 4)); end
    end
    i_flit_valid = 1'b0;
    $display("test_errors done");
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    i_req = 5'b01000; cyc(); i_req = '0;
    for (int k = 0; k < 7; k++) begin
      i_flit_valid = 1'b1; i_flit = mk((k == 0) ? T_HEAD : T_BODY, 'h50 + k); cyc();
    end
    i_flit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b0 || o_owner !== 3'd0 || o_ack !== 5'b0) begin errors++;
      $display("FAIL rstmid_alloc got busy=%b owner=%0d ack=%b exp 0 0 0", o_busy, o_owner, o_ack); end
    checks++; if (o_link_valid !== 1'b0 || o_link_flit !== 32'h0 || o_err !== 2'b00 || o_ready !== 1'b1) begin errors++;
      $display("FAIL rstmid_link got v=%b flit=%h err=%b rdy=%b exp 0 0 00 1", o_link_valid, o_link_flit, o_err, o_ready); end
    cyc(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_credit = 1'b1; cyc(); i_credit = 1'b0;
      checks++; if (o_link_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flush%0d got %b exp 0", k, o_link_valid); end
    end
    i_req = 5'b00110; cyc(); i_req = '0;
    checks++; if (o_ack !== 5'b00010 || o_owner !== 3'd1) begin errors++;
      $display("FAIL rstmid_regrant got ack=%b owner=%0d exp 00010 1", o_ack, o_owner); end
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_errors();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
